// File: rtl/aidc_lite_comp_bpc_param.sv
// aidc_lite_comp_bpc_param
// Second-generation bit-plane compressor for one AIDC-Lite block.
// A block of NUM_BEATS beats is captured, cut into SYM_W-bit symbols,
// delta / bit-plane / DBX transformed, plane-encoded and emitted as
// MSB-first packed DATA_W words.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   valid_i/sop_i/eop_i/data_i  input beats (no backpressure)
//   busy_o          block in flight; new sop is ignored while high
//   valid_o/addr_o/data_o       packed output words, addr 0,1,...
//   done_o          one-cycle end-of-block pulse
//   fail_o, len_o   incompressible flag and total bit length (with done_o)
//
// Optional feature macro: AIDC_LITE_BPC_PASSTHRU_EN
//   defined   -> an incompressible block is echoed raw (NUM_BEATS words)
//   undefined -> an incompressible block produces no output words
//
// Output handshake: valid_o is a one-cycle qualifier per word with no
// ready; done_o marks the end of the block and qualifies fail_o/len_o.
module aidc_lite_comp_bpc_param #(
  parameter  int DATA_W    = 64,
  parameter  int NUM_BEATS = 4,
  parameter  int SYM_W     = 32,
  localparam int L         = DATA_W / SYM_W,
  localparam int N         = NUM_BEATS * L,
  localparam int BLK_BITS  = NUM_BEATS * DATA_W,
  localparam int ADDR_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int RUN_W     = $clog2(SYM_W),
  localparam int IDX_W     = $clog2(N - 1),
  localparam int LEN_W     = $clog2(SYM_W + (SYM_W + 1) * N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [LEN_W-1:0]  len_o
);

  localparam int FL_W   = 2 + RUN_W;                          // longest run code
  localparam int CODE_W = (N > 5 + IDX_W) ? N : 5 + IDX_W;    // longest plane code
  localparam int CH_W   = FL_W + CODE_W;                      // bits appended per cycle
  localparam int P_W    = RUN_W + 1;                          // holds 0..SYM_W+1
  localparam int CNT_W  = $clog2(NUM_BEATS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_PREP, S_ENCODE, S_EMIT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   beats_q [NUM_BEATS];
  logic [DATA_W-1:0]   beats_d [NUM_BEATS];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [P_W-1:0]      plane_q, plane_d;
  logic [P_W-1:0]      run_q, run_d;
  logic [BLK_BITS-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   word_q, word_d;

  // ---------------- transform datapath ----------------
  logic [BLK_BITS-1:0] blk;
  logic [SYM_W:0]      delta [1:N-1];
  logic [N-2:0]        dbx;
  logic [P_W-1:0]      plane_up;

  always_comb begin
    for (int b = 0; b < NUM_BEATS; b++) blk[b*DATA_W +: DATA_W] = beats_q[b];
  end

  // Symbol k sits at blk[k*SYM_W +: SYM_W]; deltas wrap in SYM_W+1 bits.
  always_comb begin
    for (int i = 1; i < N; i++)
      delta[i] = {1'b0, blk[i*SYM_W +: SYM_W]} - {1'b0, blk[(i-1)*SYM_W +: SYM_W]};
  end

  // DBX of the current plane; d_1 lands on the MSB. The top plane has no
  // neighbour above it, so it is passed through unchanged.
  always_comb begin
    plane_up = plane_q + 1'b1;
    for (int i = 1; i < N; i++)
      dbx[N-1-i] = delta[i][plane_q] ^
                   ((plane_q == P_W'(SYM_W)) ? 1'b0 : delta[i][plane_up]);
  end

  // ---------------- plane encoder ----------------
  logic              dbx_zero, dbx_ones, dbx_one, last_plane, flush_en;
  logic [IDX_W-1:0]  one_pos;
  logic [P_W-1:0]    run_inc, flush_run;
  logic [FL_W-1:0]   fl_val;
  logic [CODE_W-1:0] cd_val;
  logic [LEN_W-1:0]  fl_len, cd_len;
  logic [CH_W-1:0]   chunk;
  logic [BLK_BITS-1:0] app_bits;

  always_comb begin
    dbx_zero = (dbx == '0);
    dbx_ones = (dbx == '1);
    dbx_one  = !dbx_zero && ((dbx & (dbx - 1'b1)) == '0);
    one_pos  = '0;
    for (int j = 0; j < N - 1; j++)
      if (dbx[j]) one_pos = IDX_W'(N - 2 - j);

    last_plane = (plane_q == '0);
    run_inc    = run_q + 1'b1;
    // A pending run is closed by a non-zero plane, or by the last plane.
    flush_en   = (!dbx_zero && (run_q != '0)) || (last_plane && dbx_zero);
    flush_run  = dbx_zero ? run_inc : run_q;

    fl_val = '0;
    fl_len = '0;
    if (flush_en) begin
      if (flush_run == P_W'(1)) begin
        fl_val = FL_W'(3'b001) << (FL_W - 3);
        fl_len = LEN_W'(3);
      end else begin
        fl_val = {2'b01, RUN_W'(flush_run - P_W'(2))};
        fl_len = LEN_W'(FL_W);
      end
    end

    cd_val = '0;
    cd_len = '0;
    if (dbx_ones) begin
      cd_len = LEN_W'(5);
    end else if (dbx_one) begin
      cd_val = CODE_W'({5'b00001, one_pos}) << (CODE_W - 5 - IDX_W);
      cd_len = LEN_W'(5 + IDX_W);
    end else if (!dbx_zero) begin
      cd_val = CODE_W'({1'b1, dbx}) << (CODE_W - N);
      cd_len = LEN_W'(N);
    end

    // Both fields are left-aligned; the plane code follows the run code.
    chunk = {fl_val, {CODE_W{1'b0}}} | ({cd_val, {FL_W{1'b0}}} >> fl_len);
    // Bits shifted past the end of the buffer are dropped (saturation).
    app_bits = (BLK_BITS'(chunk) << (BLK_BITS - CH_W)) >> len_q;
  end

  // ---------------- emit selection ----------------
  logic              fail_now, emit_last;
  logic [DATA_W-1:0] emit_word;

  always_comb begin
    fail_now  = int'(len_q) >= BLK_BITS;
    emit_last = (int'(word_q) + 1) * DATA_W >= int'(len_q);
    emit_word = buf_q[BLK_BITS-1 - int'(word_q)*DATA_W -: DATA_W];
`ifdef AIDC_LITE_BPC_PASSTHRU_EN
    if (fail_now) begin
      emit_word = beats_q[word_q];
      emit_last = (word_q == ADDR_W'(NUM_BEATS - 1));
    end
`endif
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    plane_d = plane_q;
    run_d   = run_q;
    buf_d   = buf_q;
    len_d   = len_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && sop_i) begin
          // Clearing here zero-fills any beats an early eop leaves out.
          for (int b = 0; b < NUM_BEATS; b++) beats_d[b] = '0;
          beats_d[0] = data_i;
          cnt_d      = CNT_W'(1);
          state_d    = eop_i ? S_PREP : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (valid_i) begin
          if (int'(cnt_q) < NUM_BEATS) begin
            beats_d[cnt_q[ADDR_W-1:0]] = data_i;
            cnt_d = cnt_q + 1'b1;
          end
          if (eop_i) state_d = S_PREP;
        end
      end
      S_PREP: begin
        buf_d = '0;
        buf_d[BLK_BITS-1 -: SYM_W] = blk[SYM_W-1:0];
        len_d   = LEN_W'(SYM_W);
        run_d   = '0;
        plane_d = P_W'(SYM_W);
        word_d  = '0;
        state_d = S_ENCODE;
      end
      S_ENCODE: begin
        buf_d   = buf_q | app_bits;
        len_d   = len_q + fl_len + cd_len;
        run_d   = dbx_zero ? run_inc : '0;
        plane_d = plane_q - 1'b1;
        if (last_plane) begin
`ifdef AIDC_LITE_BPC_PASSTHRU_EN
          state_d = S_EMIT;
`else
          state_d = (int'(len_d) >= BLK_BITS) ? S_DONE : S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        word_d = word_q + 1'b1;
        if (emit_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int b = 0; b < NUM_BEATS; b++) beats_q[b] <= '0;
      cnt_q   <= '0;
      plane_q <= '0;
      run_q   <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      plane_q <= plane_d;
      run_q   <= run_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      word_q  <= word_d;
    end
  end

  // Outputs are gated so idle values are always zero.
  assign busy_o  = (state_q != S_IDLE);
  assign valid_o = (state_q == S_EMIT);
  assign addr_o  = valid_o ? word_q : '0;
  assign data_o  = valid_o ? emit_word : '0;
  assign done_o  = (state_q == S_DONE);
  assign fail_o  = done_o && fail_now;
  assign len_o   = done_o ? len_q : '0;

endmodule

// File: tb/tb_aidc_lite_comp_bpc_param.sv
// Testbench for aidc_lite_comp_bpc_param: table vectors from the test plan,
// randomized blocks against a bit-queue reference model, and hand-written
// sequences for early eop, sop while busy, and reset during encode.
module tb_aidc_lite_comp_bpc_param;
  localparam int DATA_W    = 64;
  localparam int NUM_BEATS = 4;
  localparam int SYM_W     = 32;
  localparam int L         = DATA_W / SYM_W;
  localparam int N         = NUM_BEATS * L;
  localparam int BLK_BITS  = NUM_BEATS * DATA_W;
  localparam int ADDR_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int RUN_W     = $clog2(SYM_W);
  localparam int IDX_W     = $clog2(N - 1);
  localparam int LEN_W     = $clog2(SYM_W + (SYM_W + 1) * N + 1);
  localparam int LAT       = SYM_W + 3;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i, sop_i, eop_i;
  logic [DATA_W-1:0] data_i;
  logic              busy_o, valid_o, done_o, fail_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;

  always #5 clk = ~clk;

  aidc_lite_comp_bpc_param #(.DATA_W(DATA_W), .NUM_BEATS(NUM_BEATS), .SYM_W(SYM_W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i),
    .data_i(data_i), .busy_o(busy_o), .valid_o(valid_o), .addr_o(addr_o),
    .data_o(data_o), .done_o(done_o), .fail_o(fail_o), .len_o(len_o)
  );

  // ---------------- scoreboard state ----------------
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] drv_q[$];
  bit                mq[$];
  int                last_len;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_bits(input logic [63:0] v, input int w);
    for (int b = w - 1; b >= 0; b--) mq.push_back(v[b]);
  endtask

  task automatic push_run(input int r);
    if (r == 1) push_bits(64'd1, 3);
    else begin
      push_bits(64'd1, 2);
      push_bits(64'(r - 2), RUN_W);
    end
  endtask

  // Builds the expected word queue for the beats in drv_q.
  task automatic model_block(output int len, output bit fail);
    logic [BLK_BITS-1:0] blk;
    logic [63:0] s [N];
    logic [63:0] d [N];
    logic [63:0] mask;
    logic [63:0] word;
    bit  x [N-1];
    int  run, ones, pos, nw, idx;
    blk = '0;
    for (int i = 0; i < drv_q.size() && i < NUM_BEATS; i++) blk[i*DATA_W +: DATA_W] = drv_q[i];
    mask = (64'd1 << (SYM_W + 1)) - 64'd1;
    for (int k = 0; k < N; k++) s[k] = 64'(blk[k*SYM_W +: SYM_W]);
    d[0] = '0;
    for (int i = 1; i < N; i++) d[i] = (s[i] - s[i-1]) & mask;
    mq.delete();
    push_bits(s[0], SYM_W);
    run = 0;
    for (int p = SYM_W; p >= 0; p--) begin
      ones = 0;
      pos  = 0;
      for (int j = 0; j < N - 1; j++) begin
        x[j] = d[j+1][p] ^ ((p == SYM_W) ? 1'b0 : d[j+1][p+1]);
        if (x[j]) begin ones++; pos = j; end
      end
      if (ones == 0) run++;
      else begin
        if (run > 0) push_run(run);
        run = 0;
        if (ones == N - 1) push_bits(64'd0, 5);
        else if (ones == 1) begin push_bits(64'd1, 5); push_bits(64'(pos), IDX_W); end
        else begin
          mq.push_back(1'b1);
          for (int j = 0; j < N - 1; j++) mq.push_back(x[j]);
        end
      end
    end
    if (run > 0) push_run(run);
    len  = mq.size();
    fail = (len >= BLK_BITS);
    exp_q.delete();
    if (!fail) begin
      nw = (len + DATA_W - 1) / DATA_W;
      for (int w = 0; w < nw; w++) begin
        word = '0;
        for (int b = 0; b < DATA_W; b++) begin
          idx = w * DATA_W + b;
          if (idx < len) word[DATA_W-1-b] = mq[idx];
        end
        exp_q.push_back(word[DATA_W-1:0]);
      end
    end
`ifdef AIDC_LITE_BPC_PASSTHRU_EN
    else begin
      for (int i = 0; i < NUM_BEATS; i++) exp_q.push_back(blk[i*DATA_W +: DATA_W]);
    end
`endif
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0;
  endtask

  task automatic send_beats(input string tag);
    for (int i = 0; i < drv_q.size(); i++) begin
      @(negedge clk);
      if (i == 1) check({tag, "_busy_collect"}, 64'(busy_o), 64'd1);
      valid_i = 1'b1;
      sop_i   = (i == 0);
      eop_i   = (i == drv_q.size() - 1);
      data_i  = drv_q[i];
    end
  endtask

  // Collects the block's output; optionally injects a sop while busy.
  task automatic collect(input string tag, input int exp_len, input bit exp_fail,
                         input bit inject_sop);
    int k, addr, first, n_exp;
    bit got_done;
    k = 0; addr = 0; first = -1; got_done = 0;
    n_exp = exp_q.size();
    while (!got_done && k < 200) begin
      @(negedge clk);
      idle_inputs();
      k++;
      if (inject_sop && k == 3) begin
        valid_i = 1'b1; sop_i = 1'b1; eop_i = 1'b1; data_i = 64'hDEAD_BEEF_0BAD_F00D;
      end
      if (valid_o) begin
        if (first < 0) first = k;
        if (exp_q.size() == 0) check({tag, "_extra_word"}, 64'd1, 64'd0);
        else check({tag, "_word"}, 64'(data_o), 64'(exp_q.pop_front()));
        check({tag, "_addr"}, 64'(addr_o), 64'(addr));
        addr++;
      end
      if (done_o) begin
        got_done = 1;
        last_len = int'(len_o);
        check({tag, "_len"}, 64'(len_o), 64'(exp_len));
        check({tag, "_fail"}, 64'(fail_o), 64'(exp_fail));
        check({tag, "_nwords"}, 64'(addr), 64'(n_exp));
        check({tag, "_done_cycle"}, 64'(k), 64'(LAT + n_exp));
        if (n_exp > 0) check({tag, "_first_valid"}, 64'(first), 64'(LAT));
      end
    end
    if (!got_done) check({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, busy_o, done_o}, 64'd0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [NUM_BEATS-1:0][DATA_W-1:0] beats;
    int                nb;
    bit                use_model;
    logic [DATA_W-1:0] w0;
    int                exp_len;
  } vec_t;

  vec_t vecs[4];

  task automatic run_block_model(input string tag);
    int  mlen;
    bit  mfail;
    model_block(mlen, mfail);
    send_beats(tag);
    collect(tag, mlen, mfail, 1'b0);
  endtask

  initial begin
    logic [15:0] lfsr;
    logic [BLK_BITS-1:0] rblk;
    logic [SYM_W-1:0] sym;
    int mode, nb, bad;

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset_ctrl", {59'd0, busy_o, valid_o, done_o, fail_o, 1'b0} | 64'(addr_o), 64'd0);
    check("reset_len", 64'(len_o), 64'd0);
    check("reset_data", 64'(data_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test-plan table.
    vecs[0].beats = '0;
    vecs[0].nb = 4; vecs[0].use_model = 0; vecs[0].w0 = 64'h00000000_7E000000; vecs[0].exp_len = 39;
    for (int b = 0; b < NUM_BEATS; b++) vecs[1].beats[b] = 64'h12345678_12345678;
    vecs[1].nb = 4; vecs[1].use_model = 0; vecs[1].w0 = 64'h12345678_7E000000; vecs[1].exp_len = 39;
    for (int b = 0; b < NUM_BEATS; b++) vecs[2].beats[b] = {32'(2*b+1), 32'(2*b)};
    vecs[2].nb = 4; vecs[2].use_model = 0; vecs[2].w0 = 64'h00000000_7C000000; vecs[2].exp_len = 44;
    lfsr = 16'hACE1;
    for (int c = 0; c < BLK_BITS / 16; c++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rblk[c*16 +: 16] = lfsr;
    end
    for (int b = 0; b < NUM_BEATS; b++) vecs[3].beats[b] = rblk[b*DATA_W +: DATA_W];
    vecs[3].nb = 4; vecs[3].use_model = 1; vecs[3].w0 = '0; vecs[3].exp_len = 0;

    for (int v = 0; v < 4; v++) begin
      drv_q.delete();
      for (int b = 0; b < vecs[v].nb; b++) drv_q.push_back(vecs[v].beats[b]);
      if (vecs[v].use_model) begin
        run_block_model($sformatf("vec%0d", v));
        checks++;
        if (last_len < BLK_BITS) begin
          errors++;
          $display("FAIL vec%0d_len_ge got=%0d exp>=%0d", v, last_len, BLK_BITS);
        end
      end else begin
        exp_q.delete();
        exp_q.push_back(vecs[v].w0);
        send_beats($sformatf("vec%0d", v));
        collect($sformatf("vec%0d", v), vecs[v].exp_len, 1'b0, 1'b0);
      end
    end

    // Early eop on beat 1 of a zero block, then sop while busy.
    drv_q.delete();
    drv_q.push_back('0);
    drv_q.push_back('0);
    exp_q.delete();
    exp_q.push_back(64'h00000000_7E000000);
    send_beats("early_eop");
    collect("early_eop", 39, 1'b0, 1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_o || valid_o || done_o) bad++;
    end
    check("sop_busy_ignored", 64'(bad), 64'd0);

    // Reset asserted during ENCODE.
    drv_q.delete();
    for (int b = 0; b < NUM_BEATS; b++) drv_q.push_back(64'h0F0F_0000_1111_2222);
    send_beats("rst_enc");
    repeat (10) begin
      @(negedge clk);
      idle_inputs();
    end
    check("rst_enc_busy_before", 64'(busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_enc_ctrl", {60'd0, busy_o, valid_o, done_o, fail_o}, 64'd0);
    check("rst_enc_len", 64'(len_o), 64'd0);
    check("rst_enc_data", {62'd0, addr_o} | 64'(data_o), 64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy_o || valid_o || done_o) bad++;
    end
    check("rst_enc_quiet", 64'(bad), 64'd0);
    drv_q.delete();
    for (int b = 0; b < NUM_BEATS; b++) drv_q.push_back({32'(2*b+1), 32'(2*b)});
    exp_q.delete();
    exp_q.push_back(64'h00000000_7C000000);
    send_beats("post_rst");
    collect("post_rst", 44, 1'b0, 1'b0);

    // Randomized blocks: random, ramps, constant, sparse; short and long.
    for (int t = 0; t < 24; t++) begin
      mode = $urandom_range(0, 3);
      nb   = $urandom_range(1, NUM_BEATS + 2);
      rblk = '0;
      sym  = SYM_W'($urandom);
      for (int k = 0; k < N; k++) begin
        case (mode)
          0: sym = SYM_W'($urandom);
          1: sym = sym + SYM_W'($urandom_range(0, 3));
          2: sym = sym;
          default: sym = ($urandom_range(0, 3) == 0) ? SYM_W'(1) << $urandom_range(0, SYM_W-1) : '0;
        endcase
        rblk[k*SYM_W +: SYM_W] = sym;
      end
      drv_q.delete();
      for (int b = 0; b < nb; b++)
        drv_q.push_back((b < NUM_BEATS) ? rblk[b*DATA_W +: DATA_W] : DATA_W'($urandom));
      run_block_model($sformatf("rnd%0d_m%0d_nb%0d", t, mode, nb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
